// File: rtl/bloke2s_arbiter.sv
// bloke2s_arbiter: round-robin owner selection and start/finish
// sequencing for one bloke2s core shared by NREQ requesters.
module bloke2s_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_grant,
  input  logic [8*NREQ-1:0] req_din,
  input  logic [NREQ-1:0]   req_din_valid,
  output logic [NREQ-1:0]   req_din_ready,
  input  logic [NREQ-1:0]   req_end,
  output logic [7:0]        rsp_dout,
  output logic [NREQ-1:0]   rsp_dout_valid,
  output logic [NREQ-1:0]   rsp_dout_end,
  output logic              busy,
  output logic [IDX_W-1:0]  owner,
  output logic              core_start,
  output logic              core_finish,
  output logic [7:0]        core_din,
  output logic              core_din_valid,
  output logic              core_din_end,
  input  logic              core_din_ready,
  input  logic [7:0]        core_dout,
  input  logic              core_dout_valid,
  input  logic              core_dout_end
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_RDY,
    STREAM,
    FINISH,
    DRAIN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] last_nxt;
  logic [IDX_W-1:0] owner_nxt;
  logic [IDX_W-1:0] pick;
  logic             any;
  int               arb_j;
  logic [NREQ-1:0]  sel;
  logic             own_valid;
  logic             own_end;

  // Descending scan so the nearest requester after last wins.
  always_comb begin
    pick  = '0;
    any   = 1'b0;
    arb_j = 0;
    for (int k = NREQ; k >= 1; k--) begin
      arb_j = (int'(last) + k) % NREQ;
      if (|(req_valid & (NREQ'(1) << arb_j))) begin
        pick = IDX_W'(arb_j);
        any  = 1'b1;
      end
    end
  end

  assign sel       = NREQ'(1) << owner;
  assign own_valid = |(req_din_valid & sel);
  assign own_end   = |(req_end & sel);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (any) begin
          owner_nxt = pick;
          state_nxt = START;
        end
      end
      START:    state_nxt = WAIT_RDY;
      WAIT_RDY: if (core_din_ready) state_nxt = STREAM;
      STREAM:   if (own_end && !own_valid) state_nxt = FINISH;
      FINISH:   state_nxt = DRAIN;
      DRAIN: begin
        if (core_dout_end) begin
          last_nxt  = owner;
          state_nxt = IDLE;
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= IDX_W'(NREQ - 1);
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    busy           = (state != IDLE);
    req_grant      = busy ? sel : '0;
    core_start     = (state == START);
    core_finish    = (state == FINISH);
    core_din       = '0;
    core_din_valid = 1'b0;
    core_din_end   = 1'b0;
    req_din_ready  = '0;
    rsp_dout       = '0;
    rsp_dout_valid = '0;
    rsp_dout_end   = '0;
    if (state == STREAM) begin
      core_din       = 8'(req_din >> {owner, 3'b000});
      core_din_valid = own_valid;
      core_din_end   = own_valid & own_end;
      req_din_ready  = core_din_ready ? sel : '0;
    end
    if (state == DRAIN) begin
      rsp_dout       = core_dout;
      rsp_dout_valid = core_dout_valid ? sel : '0;
      rsp_dout_end   = core_dout_end ? sel : '0;
    end
  end

endmodule

// File: tb/tb_bloke2s_arbiter.sv
// tb_bloke2s_arbiter: sessions driven through a core stub and
// checked against a round-robin reference model.
module tb_bloke2s_arbiter;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_grant;
  logic [8*NREQ-1:0] req_din;
  logic [NREQ-1:0]   req_din_valid;
  logic [NREQ-1:0]   req_din_ready;
  logic [NREQ-1:0]   req_end;
  logic [7:0]        rsp_dout;
  logic [NREQ-1:0]   rsp_dout_valid;
  logic [NREQ-1:0]   rsp_dout_end;
  logic              busy;
  logic [IDX_W-1:0]  owner;
  logic              core_start;
  logic              core_finish;
  logic [7:0]        core_din;
  logic              core_din_valid;
  logic              core_din_end;
  logic              core_din_ready;
  logic [7:0]        core_dout;
  logic              core_dout_valid;
  logic              core_dout_end;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          m_last   = NREQ - 1;
  byte unsigned tx[$];

  always #5 clk = ~clk;

  bloke2s_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_grant      (req_grant),
    .req_din        (req_din),
    .req_din_valid  (req_din_valid),
    .req_din_ready  (req_din_ready),
    .req_end        (req_end),
    .rsp_dout       (rsp_dout),
    .rsp_dout_valid (rsp_dout_valid),
    .rsp_dout_end   (rsp_dout_end),
    .busy           (busy),
    .owner          (owner),
    .core_start     (core_start),
    .core_finish    (core_finish),
    .core_din       (core_din),
    .core_din_valid (core_din_valid),
    .core_din_end   (core_din_end),
    .core_din_ready (core_din_ready),
    .core_dout      (core_dout),
    .core_dout_valid(core_dout_valid),
    .core_dout_end  (core_dout_end)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid       = '0;
    req_din         = '0;
    req_din_valid   = '0;
    req_end         = '0;
    core_din_ready  = 1'b0;
    core_dout       = '0;
    core_dout_valid = 1'b0;
    core_dout_end   = 1'b0;
  endtask

  task automatic fill(input int n);
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back(8'($urandom_range(0, 254)));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_grant"}, 32'(req_grant), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_owner"}, 32'(owner), 32'(0));
    chk({tag, "_start"}, 32'(core_start), 32'(0));
    chk({tag, "_finish"}, 32'(core_finish), 32'(0));
    chk({tag, "_din_valid"}, 32'(core_din_valid), 32'(0));
    chk({tag, "_din"}, 32'(core_din), 32'(0));
    chk({tag, "_din_ready"}, 32'(req_din_ready), 32'(0));
    chk({tag, "_rsp_valid"}, 32'(rsp_dout_valid), 32'(0));
    chk({tag, "_rsp_end"}, 32'(rsp_dout_end), 32'(0));
    chk({tag, "_rsp_dout"}, 32'(rsp_dout), 32'(0));
  endtask

  // One whole session; called at posedge+1 with the DUT idle.
  task automatic session(input logic [NREQ-1:0] mask, input bit bp,
                         input bit intr, input bit end_last,
                         input bit rst_drain);
    int exp, pos, k, wait_n, bp_left, len;
    bit in_wait, streaming, fin_due, draining, done, bp_done;
    bit ov, oe, nxt_fin, was_fin;
    logic [NREQ-1:0] oh;
    byte unsigned dig[4];
    byte unsigned sum, x;
    exp = -1;
    for (int i = 1; i <= NREQ; i++)
      if (exp < 0 && ((mask >> ((m_last + i) % NREQ)) & 1) != 0)
        exp = (m_last + i) % NREQ;
    oh  = NREQ'(1) << exp;
    len = tx.size();
    sum = 0;
    x   = 0;
    foreach (tx[i]) begin
      sum = sum + tx[i];
      x   = x ^ tx[i];
    end
    dig[0] = sum;
    dig[1] = x;
    dig[2] = 8'(len);
    dig[3] = 8'(8'hA5 ^ exp);

    idle_inputs();
    req_valid = mask;
    #1;
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_grant", 32'(req_grant), 32'(0));
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    chk("start_grant", 32'(req_grant), 32'(oh));
    chk("start_busy", 32'(busy), 32'(1));
    chk("start_owner", 32'(owner), 32'(exp));
    chk("start_pulse", 32'(core_start), 32'(1));
    chk("start_nofin", 32'(core_finish), 32'(0));
    chk("start_din_valid", 32'(core_din_valid), 32'(0));
    chk("start_din_ready", 32'(req_din_ready), 32'(0));
    @(posedge clk); #1;

    pos = 0; k = 0; bp_left = 0;
    wait_n = $urandom_range(0, 3);
    in_wait = 1; streaming = 0; fin_due = 0; draining = 0;
    done = 0; bp_done = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (streaming && bp && !bp_done && pos == len / 2 && pos < len) begin
        bp_left = 3;
        bp_done = 1;
      end
      if (in_wait) core_din_ready = (wait_n == 0);
      else if (streaming) core_din_ready = (bp_left == 0);
      else core_din_ready = 1'($urandom_range(0, 1));

      ov = pos < len && (bp_left > 0 || (end_last && pos == len - 1) ||
                         $urandom_range(0, 3) != 0);
      oe = (pos >= len) || (end_last && pos == len - 1);
      req_din = intr ? '1 : 32'($urandom);
      req_din = (req_din & ~(32'hFF << (8 * exp))) |
                (32'(pos < len ? tx[pos] : 8'h00) << (8 * exp));
      req_din_valid = (intr ? ~oh : '0) | (ov ? oh : '0);
      req_end = (oe ? oh : '0) | (NREQ'($urandom) & ~oh);

      core_dout       = 8'($urandom);
      core_dout_valid = 1'b0;
      core_dout_end   = 1'b0;
      if (draining && $urandom_range(0, 2) != 0) begin
        core_dout       = dig[k];
        core_dout_valid = 1'b1;
        core_dout_end   = (k == 3);
      end

      if (rst_drain && draining) begin
        #1;
        chk("pre_rst_grant", 32'(req_grant), 32'(oh));
        rst_n = 1'b0;
        #1;
        reset_checks("rst_drain");
        rst_n  = 1'b1;
        m_last = NREQ - 1;
        idle_inputs();
        @(posedge clk); #1;
        return;
      end

      #1;
      chk("grant", 32'(req_grant), 32'(oh));
      chk("busy", 32'(busy), 32'(1));
      chk("start_once", 32'(core_start), 32'(0));
      chk("finish", 32'(core_finish), 32'(fin_due));
      chk("din_valid", 32'(core_din_valid), 32'(streaming && ov));
      chk("din_end", 32'(core_din_end), 32'(streaming && ov && oe));
      chk("din_ready", 32'(req_din_ready),
          32'((streaming && core_din_ready) ? oh : '0));
      if (streaming && ov) chk("din_byte", 32'(core_din), 32'(tx[pos]));
      if (intr) chk("iso_din", 32'(core_din == 8'hFF), 32'(0));
      chk("rsp_valid", 32'(rsp_dout_valid),
          32'((draining && core_dout_valid) ? oh : '0));
      chk("rsp_end", 32'(rsp_dout_end),
          32'((draining && core_dout_end) ? oh : '0));
      if (draining && core_dout_valid)
        chk("rsp_byte", 32'(rsp_dout), 32'(dig[k]));

      nxt_fin = streaming && oe && !ov;
      if (streaming && ov && core_din_ready) pos++;
      if (draining && core_dout_valid) begin
        if (k == 3) done = 1;
        k++;
      end
      if (bp_left > 0) bp_left--;
      was_fin = fin_due;
      fin_due = nxt_fin;
      if (nxt_fin) streaming = 0;
      if (was_fin) draining = 1;
      if (in_wait) begin
        if (core_din_ready) begin
          in_wait   = 0;
          streaming = 1;
        end else begin
          wait_n--;
        end
      end
      @(posedge clk); #1;
    end

    chk("drain_done", 32'(done), 32'(1));
    chk("bytes_sent", 32'(pos), 32'(len));
    idle_inputs();
    #1;
    chk("end_grant", 32'(req_grant), 32'(0));
    chk("end_busy", 32'(busy), 32'(0));
    chk("end_owner", 32'(owner), 32'(exp));
    chk("end_rsp_valid", 32'(rsp_dout_valid), 32'(0));
    m_last = exp;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #1;
    reset_checks("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    tx = {8'h61, 8'h62, 8'h63};
    session(4'b0001, 0, 0, 0, 0);
    tx.delete();
    session(4'b0010, 0, 0, 0, 0);

    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_last = NREQ - 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      fill($urandom_range(1, 6));
      session(4'b1111, 0, 0, 1'($urandom_range(0, 1)), 0);
    end
    fill(2);
    session(4'b0100, 0, 0, 0, 0);
    fill(3);
    session(4'b1010, 0, 0, 1, 0);

    fill(5);
    session(4'b0001, 0, 1, 0, 0);
    fill(6);
    session(4'b0100, 1, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      fill($urandom_range(0, 8));
      session(NREQ'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    fill(2);
    session(4'b1111, 0, 0, 0, 1);
    fill(3);
    session(4'b1000, 0, 0, 0, 0);
    fill(1);
    session(4'b1111, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
